nsnrlatch_writer: RTL
=====================

Name: nsnrlatch_writer

Overview:
Clocked write controller for an nset/nrst cross-coupled SR latch cell.
- Takes a single-cycle write request with a target value.
- Drives timed active-low set or reset pulses onto the latch inputs.
- Reads back the latch q/nq and acknowledges the write, retrying and flagging an error on mismatch.
- Sits between synchronous control logic and a latch-based storage or flag cell.

Parameters:
PULSE_CYC, 2, cycles lnset/lnrst is held low per attempt (>=1)
SETTLE_CYC, 2, cycles both latch inputs are held high before readback (>=1)
RETRY_MAX, 1, extra attempts after a failed readback (>=0)

Ports:
ck  input  1  clock; all state updates on rising edge
nrst  input  1  synchronous active-low reset; sampled on rising edge of ck
req  input  1  write request, single-cycle pulse; accepted only in IDLE
val  input  1  target latch value, sampled with accepted req
lq  input  1  latch q readback
lnq  input  1  latch nq readback
lnset  output  1  active-low set drive to latch
lnrst  output  1  active-low reset drive to latch
busy  output  1  high from accept edge until return to IDLE
ack  output  1  one-cycle completion pulse
err  output  1  sticky failure flag; cleared on next accepted req

Behaviour:
- Reset, nrst low at a rising edge: next cycle lnset=1, lnrst=1, busy=0, ack=0, err=0, counters=0, state IDLE.
- Reset mid-operation aborts the pulse immediately at that edge. No ack is issued and latch contents are not guaranteed.
- All outputs are registered. No combinational path from any input to any output.
- Invariant: lnset and lnrst are never both low in any cycle.
- States:
  - IDLE: req=1 captures val, clears err, sets busy, zeroes the retry count, goes to PULSE. req=0 stays.
  - PULSE: lnset=0 if captured val=1, else lnrst=0, for exactly PULSE_CYC cycles. Then go to SETTLE.
  - SETTLE: lnset=lnrst=1 for exactly SETTLE_CYC cycles. Then go to CHECK.
  - CHECK, one cycle, pass condition lq==val and lnq==~val:
    - Pass: go to DONE.
    - Fail with retry count < RETRY_MAX: increment the count, go to PULSE.
    - Fail with count == RETRY_MAX: set err=1, go to DONE.
    - lq==lnq (invalid latch state) counts as a fail.
  - DONE: ack=1 for one cycle, busy=0 next cycle, go to IDLE.
- Latency:
  - Accepting edge E0. lnset or lnrst is low during cycles E0..E0+PULSE_CYC.
  - ack is high in the cycle after edge E0+PULSE_CYC+SETTLE_CYC+1; defaults give edge E0+5.
  - Each retry adds PULSE_CYC+SETTLE_CYC+1 cycles.
- Requests:
  - A req while busy=1 is dropped, not queued; this includes the DONE cycle.
  - A req in the first IDLE cycle after DONE is accepted.
- err holds through IDLE until the next accepted req. ack and err are asserted together on failure.
- Counter width is clog2(max(PULSE_CYC,SETTLE_CYC)+1). The retry counter width is clog2(RETRY_MAX+1), minimum 1.

Optional Feature:
- Macro: NSNRLATCH_WRITER_SKIP_EN.
- Defined: at accept, if lq==val and lnq==~val, skip PULSE/SETTLE/CHECK and go directly to DONE. ack follows at edge E0+1, lnset and lnrst stay high, err=0.
- Undefined: every accepted request runs the full pulse sequence regardless of readback.

Test Plan:
- Reset then idle: nrst=0 for 2 edges, release -> lnset=lnrst=1, busy=ack=err=0; no transitions for 10 cycles.
- Set write, defaults, latch model follows inputs: req=1,val=1 at E0 -> lnset=0 during E0..E2, lnrst=1 throughout, ack=1 after E5 for exactly 1 cycle, err=0, busy falls after E6.
- Reset write: val=0 with latch at q=1 -> lnrst low 2 cycles, lnset never low, ack after E5, lq=0/lnq=1 at end.
- Stuck latch, lq forced 0, val=1, RETRY_MAX=1 -> two lnset pulses separated by 3 high cycles, ack with err=1 after E10; err stays 1 until the next req, which clears it at its accept edge.
- Busy drop and mid-reset: req pulsed at E2 during a write -> ignored, exactly one ack. Separate run: nrst=0 at E1 -> lnset high from the next cycle, no ack, busy=0.
- SKIP: with NSNRLATCH_WRITER_SKIP_EN and latch already q=1, req val=1 -> ack after E1, no lnset pulse. Without the macro, the same stimulus gives the full 5-cycle sequence.

Source files
------------

// File: rtl/nsnrlatch_writer.sv
// nsnrlatch_writer: clocked write controller for an nset/nrst cross-coupled
// SR latch. A request drives a timed active-low set or reset pulse, lets the
// latch settle, reads q/nq back, retries on mismatch and flags a sticky error
// once all retries are spent.
//
// Optional build macro: NSNRLATCH_WRITER_SKIP_EN
//   When defined, a request whose target already matches the latch readback
//   skips the pulse sequence and completes one cycle after acceptance.
module nsnrlatch_writer #(
    parameter int PULSE_CYC  = 2,  // cycles lnset/lnrst held low per attempt
    parameter int SETTLE_CYC = 2,  // cycles both inputs held high before readback
    parameter int RETRY_MAX  = 1   // extra attempts after a failed readback
) (
    input  logic ck,
    input  logic nrst,
    input  logic req,
    input  logic val,
    input  logic lq,
    input  logic lnq,
    output logic lnset,
    output logic lnrst,
    output logic busy,
    output logic ack,
    output logic err
);

    localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIM   = RW'(RETRY_MAX);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    logic          tgt;
    logic          readback_ok;
    logic          already_ok;

    // Latch agrees with the captured target; q==nq can never satisfy this.
    assign readback_ok = (lq == tgt) && (lnq == ~tgt);
    // Latch already holds the value carried by the incoming request.
    assign already_ok  = (lq == val) && (lnq == ~val);

    // Single-process FSM; every output is a register so no input reaches an
    // output combinationally, and only one of lnset/lnrst is ever driven low.
    always_ff @(posedge ck) begin
        // NOTE: reset sits inside the clocked block so it is sampled on ck;
        // all state uses <= so every branch sees pre-edge values.
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
            retry <= '0;
            tgt   <= 1'b0;
            lnset <= 1'b1;
            lnrst <= 1'b1;
            busy  <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        tgt   <= val;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        retry <= '0;
                        cnt   <= '0;
`ifdef NSNRLATCH_WRITER_SKIP_EN
                        if (already_ok) begin
                            state <= DONE;
                        end else begin
                            state <= PULSE;
                            lnset <= ~val;
                            lnrst <= val;
                        end
`else
                        state <= PULSE;
                        lnset <= ~val;
                        lnrst <= val;
`endif
                    end
                end

                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        state <= SETTLE;
                        cnt   <= '0;
                        lnset <= 1'b1;
                        lnrst <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= CHECK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                CHECK: begin
                    if (readback_ok) begin
                        state <= DONE;
                        ack   <= 1'b1;
                    end else if (retry < RETRY_LIM) begin
                        state <= PULSE;
                        retry <= retry + 1'b1;
                        cnt   <= '0;
                        lnset <= ~tgt;
                        lnrst <= tgt;
                    end else begin
                        state <= DONE;
                        ack   <= 1'b1;
                        err   <= 1'b1;
                    end
                end

                DONE: begin
                    // The skip path enters with ack still low and raises it here.
                    if (!ack) begin
                        ack <= 1'b1;
                    end else begin
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    lnset <= 1'b1;
                    lnrst <= 1'b1;
                    busy  <= 1'b0;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

    // already_ok is only consumed when the skip feature is built in.
    logic unused_ok;
    assign unused_ok = already_ok;

endmodule
